// File: rtl/vga_timing_pkg.sv
// Shared 640x480 raster constants, coordinate type and range helper used by
// the sync generator and the bitmap stage that consumes its scan position.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  // Visible box drawn by the bitmap stage, inclusive bounds.
  localparam int BOX_X_LO = 192;
  localparam int BOX_X_HI = 447;
  localparam int BOX_Y_LO = 112;
  localparam int BOX_Y_HI = 367;

  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: the generator drives it, downstream display stages read it.
interface vga_sync_gen_if;
  logic                    pixel_tick;
  vga_timing_pkg::coord_t  pixel_x;
  vga_timing_pkg::coord_t  pixel_y;
  logic                    video_on;
  logic                    hsync;
  logic                    vsync;
  logic                    line_tick;
  logic                    frame_tick;

  modport master (
    output pixel_tick, pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick
  );

  modport slave (
    input  pixel_tick, pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable. Exposes both the register and its next value
// so callers can decode registered outputs aligned with the count.
module vga_mod_counter #(
  parameter int N       = 2,
  parameter int W       = 12,
  parameter bit RST_TOP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_d_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] TOP     = W'(N - 1);
  localparam logic [W-1:0] RST_VAL = RST_TOP ? TOP : '0;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == TOP) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign wrap_o  = en_i && (cnt_q == TOP);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: clock-enable pixel divider, h/v scan counters and
// registered sync/blank/tick decodes that always match the shown position.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = 4,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam coord_t H_VIS = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_wrap;
  coord_t           h_q, h_d, v_q, v_d;
  logic             h_wrap, v_wrap;

  logic pixel_tick_q, line_tick_q, frame_tick_q;
  logic video_on_q, hsync_q, vsync_q;

  // Divider count itself is not observed; only its wrap matters.
  logic unused_div;
  assign unused_div = ^{div_q, div_d};

  vga_mod_counter #(.N(CLK_DIV), .W(DIV_W), .RST_TOP(1'b0)) u_div (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .cnt_o   (div_q),
    .cnt_d_o (div_d),
    .wrap_o  (div_wrap)
  );

  // Reset parks the scan on the last blank pixel so the first step lands on (0,0).
  vga_mod_counter #(.N(H_TOT), .W(COORD_W), .RST_TOP(1'b1)) u_h (
    .clk     (clk),
    .rst     (rst),
    .en_i    (pixel_tick_q),
    .cnt_o   (h_q),
    .cnt_d_o (h_d),
    .wrap_o  (h_wrap)
  );

  vga_mod_counter #(.N(V_TOT), .W(COORD_W), .RST_TOP(1'b1)) u_v (
    .clk     (clk),
    .rst     (rst),
    .en_i    (h_wrap),
    .cnt_o   (v_q),
    .cnt_d_o (v_d),
    .wrap_o  (v_wrap)
  );

  // Decodes use next-state counts so they change on the same edge as pixel_x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_tick_q <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      video_on_q   <= 1'b0;
      hsync_q      <= !SYNC_POL;
      vsync_q      <= !SYNC_POL;
    end else begin
      pixel_tick_q <= div_wrap;
      line_tick_q  <= h_wrap;
      frame_tick_q <= h_wrap && v_wrap;
      video_on_q   <= (h_d < H_VIS) && (v_d < V_VIS);
      hsync_q      <= in_range(h_d, HS_LO, HS_HI) ? SYNC_POL : !SYNC_POL;
      vsync_q      <= in_range(v_d, VS_LO, VS_HI) ? SYNC_POL : !SYNC_POL;
    end
  end

  assign vga.pixel_tick = pixel_tick_q;
  assign vga.pixel_x    = h_q;
  assign vga.pixel_y    = v_q;
  assign vga.video_on   = video_on_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.line_tick  = line_tick_q;
  assign vga.frame_tick = frame_tick_q;

endmodule
